mmio_timer: RTL
===============

# mmio_timer

Memory-mapped timer peripheral sitting on the responder side of the CPU data-memory bus (`addr`, `wdata`, `mm_we`, `mm_re` in; `rdata` out). It decodes a small register window, services CPU reads and writes, and runs a prescaled 16-bit up-counter with compare match, overflow detection and an optional interrupt. Its `rdata` is ORed with other responders into the CPU's read-data input, so it drives zero whenever it is not addressed.

## Interface
- `BASE_ADDR`, 16'hC000: window base; bits [2:0] must be zero; window is 8 words.
- `PRESC_W`, 8: prescaler width; must be 8 or less, because the prescale field is CTRL[15:8].
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `addr` in 16: CPU word address.
- `wdata` in 16: CPU write data.
- `mm_we` in 1: write strobe, one cycle per write.
- `mm_re` in 1: read strobe, one cycle per read.
- `rdata` out 16: read data, registered; zero when not returning a hit.
- `irq` out 1: level interrupt request.

## Operation
- Hit: `addr[15:3] == BASE_ADDR[15:3]`. The offset is `addr[2:0]`.
- Registers:
  - 0 CTRL (r/w): [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [15:8] PRESC. Bits [7:3] read 0.
  - 1 COUNT (r/w).
  - 2 COMPARE (r/w).
  - 3 STATUS: [0] MATCH, [1] OVF. Both bits are sticky and write-1-to-clear.
  - 4–7: read 0; writes are ignored.
- Prescaler: counts 0..PRESC while EN=1. `tick` pulses when the prescaler equals PRESC, and the prescaler then returns to 0.
  - PRESC=0 gives a tick every cycle.
  - Any CTRL write clears the prescaler.
- On `tick`:
  - If COUNT==COMPARE: set MATCH. COUNT becomes 0 if AUTO_RELOAD=1, otherwise COUNT+1.
  - Otherwise COUNT becomes COUNT+1.
  - If COUNT==16'hFFFF and it is incremented: COUNT wraps to 0 and OVF is set.
- EN=0: prescaler and COUNT hold; register access is unaffected.
- Simultaneous events:
  - A CPU write to COUNT in a tick cycle wins; the tick is discarded, with no MATCH or OVF set from it.
  - A W1C clear and a hardware set of the same STATUS bit in one cycle: the set wins.
  - `mm_we` and `mm_re` to the same register in one cycle: the write takes effect, and the read returns the pre-write value.
- A write with no hit has no effect. A read with no hit makes the next `rdata` 0.

## Timing
- Reset values: all registers 0, prescaler 0, `rdata`=0, `irq`=0.
- Write: the register is updated at the clock edge where `mm_we`=1. The new value is visible to a read issued on the following cycle.
- Read latency 1: `rdata` in cycle N+1 holds the register value sampled at the edge ending cycle N, where `mm_re`=1 in cycle N.
  - In every other cycle `rdata` is 0.
- Tick to COUNT: COUNT changes at the same edge where `tick` is high. MATCH and OVF are set at that same edge.
- `irq` is registered, so it rises one cycle after the flag sets. It falls one cycle after the flags clear or IRQ_EN is written to 0.
- Reset asserted mid-operation clears everything immediately, including a pending `rdata`. The first access after `rst_n` rises is serviced normally.

## Configuration
- `MMIO_TIMER_IRQ_EN` defined:
  - `irq` = registered (IRQ_EN & (MATCH | OVF)).
  - CTRL[2] is writable.
- Not defined:
  - `irq` is tied to 0.
  - CTRL[2] is not implemented: it reads 0 and writes are ignored.
  - Polling STATUS still works.

## Structure
- Package `mmio_timer_pkg` holds:
  - offset constants `OFF_CTRL`, `OFF_COUNT`, `OFF_COMPARE`, `OFF_STATUS`;
  - CTRL and STATUS bit-position localparams;
  - a packed `ctrl_t` struct.
- Sub-module `mmio_prescaler`:
  - inputs: `clk`, `rst_n`, `en`, `clr`, `presc[PRESC_W-1:0]`;
  - output: `tick`.
- Top level contains the bus decode, register file, counter and compare, flags, `irq`, and the `rdata` register.

## Test plan
- Reset, then read offsets 0–7 → `rdata`=0 on each cycle after the read strobe; `irq`=0.
- Write COMPARE=5, then CTRL=16'h0003 (EN, AUTO_RELOAD, PRESC=0) → COUNT goes 0..5,0,1…; MATCH sets on the edge where COUNT 5→0; STATUS reads 16'h0001.
- Write COUNT=16'hFFFE, CTRL=16'h0401 (PRESC=4) → one increment every 5 cycles; after 10 cycles COUNT=0 and OVF=1. Then write STATUS=16'h0002 → OVF clears, MATCH is unaffected.
- With the macro defined: CTRL=16'h0005, COMPARE=3 → `irq` rises one cycle after MATCH sets. Writing STATUS=1 in the same cycle as a new match → MATCH stays 1.
- Write COUNT=16'h1234 in a tick cycle → COUNT reads 16'h1234 and no MATCH is set. A read of address 16'hB000 → `rdata`=0.
- Assert `rst_n`=0 during a read with `rdata`=16'h1234 pending → `rdata`, COUNT, CTRL and STATUS all read 0 after release.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// Shared register offsets, bit positions and the CTRL layout for mmio_timer.
package mmio_timer_pkg;

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_COUNT   = 3'd1;
    localparam logic [2:0] OFF_COMPARE = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd3;

    localparam int CTRL_EN_BIT          = 0;
    localparam int CTRL_AUTO_RELOAD_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT      = 2;
    localparam int CTRL_PRESC_LSB       = 8;

    localparam int STATUS_MATCH_BIT = 0;
    localparam int STATUS_OVF_BIT   = 1;

    typedef struct packed {
        logic [7:0] presc;
        logic [4:0] rsvd;
        logic       irq_en;
        logic       auto_reload;
        logic       en;
    } ctrl_t;

    function automatic logic [15:0] status_word(input logic match, input logic ovf);
        logic [15:0] w;
        w = '0;
        w[STATUS_MATCH_BIT] = match;
        w[STATUS_OVF_BIT]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/mmio_prescaler.sv
// Free-running 0..presc divider producing a one-cycle tick while enabled.
module mmio_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt_reg;

    assign tick = en && (cnt_reg == presc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 16-bit timer with compare match and overflow flags.
// Define MMIO_TIMER_IRQ_EN to implement CTRL.IRQ_EN and drive the irq output.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hC000,
    parameter int          PRESC_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        mm_we,
    input  logic        mm_re,
    output logic [15:0] rdata,
    output logic        irq
);

    ctrl_t       ctrl_reg;
    logic [15:0] count_reg, count_next;
    logic [15:0] compare_reg;
    logic        match_reg, match_next;
    logic        ovf_reg, ovf_next;
    logic [15:0] rdata_reg;
    logic [15:0] rd_word;
    logic [7:0]  presc_mask;
    logic        hit, tick;
    logic        wr_ctrl, wr_count, wr_compare, wr_status;
    logic        match_set, ovf_set, reload;
    logic [2:0]  off;

    assign hit        = (addr[15:3] == BASE_ADDR[15:3]);
    assign off        = addr[2:0];
    assign wr_ctrl    = mm_we && hit && (off == OFF_CTRL);
    assign wr_count   = mm_we && hit && (off == OFF_COUNT);
    assign wr_compare = mm_we && hit && (off == OFF_COMPARE);
    assign wr_status  = mm_we && hit && (off == OFF_STATUS);

    // PRESC bits beyond the prescaler width are not stored and read back 0.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_presc_mask
            assign presc_mask[gi] = (gi < PRESC_W);
        end
    endgenerate

    mmio_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl_reg.en),
        .clr   (wr_ctrl),
        .presc (ctrl_reg.presc[PRESC_W-1:0]),
        .tick  (tick)
    );

    // A CPU write to COUNT discards the tick in the same cycle, flags included.
    always_comb begin
        count_next = count_reg;
        match_set  = 1'b0;
        ovf_set    = 1'b0;
        reload     = 1'b0;
        if (wr_count) begin
            count_next = wdata;
        end else if (tick) begin
            match_set  = (count_reg == compare_reg);
            reload     = match_set && ctrl_reg.auto_reload;
            count_next = reload ? 16'h0000 : count_reg + 16'd1;
            ovf_set    = !reload && (count_reg == 16'hFFFF);
        end
        match_next = (match_reg && !(wr_status && wdata[STATUS_MATCH_BIT])) || match_set;
        ovf_next   = (ovf_reg   && !(wr_status && wdata[STATUS_OVF_BIT]))   || ovf_set;
    end

    always_comb begin
        rd_word = '0;
        case (off)
            OFF_CTRL:    rd_word = ctrl_reg;
            OFF_COUNT:   rd_word = count_reg;
            OFF_COMPARE: rd_word = compare_reg;
            OFF_STATUS:  rd_word = status_word(match_reg, ovf_reg);
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg    <= '0;
            count_reg   <= '0;
            compare_reg <= '0;
            match_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_reg.en          <= wdata[CTRL_EN_BIT];
                ctrl_reg.auto_reload <= wdata[CTRL_AUTO_RELOAD_BIT];
`ifdef MMIO_TIMER_IRQ_EN
                ctrl_reg.irq_en      <= wdata[CTRL_IRQ_EN_BIT];
`else
                ctrl_reg.irq_en      <= 1'b0;
`endif
                ctrl_reg.presc       <= wdata[CTRL_PRESC_LSB +: 8] & presc_mask;
            end
            if (wr_compare) begin
                compare_reg <= wdata;
            end
            count_reg <= count_next;
            match_reg <= match_next;
            ovf_reg   <= ovf_next;
            rdata_reg <= (mm_re && hit) ? rd_word : 16'h0000;
        end
    end

    assign rdata = rdata_reg;

`ifdef MMIO_TIMER_IRQ_EN
    logic irq_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= ctrl_reg.irq_en && (match_reg || ovf_reg);
        end
    end

    assign irq = irq_reg;
`else
    assign irq = 1'b0;
`endif

endmodule
